// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among R requesters.
// Define REGFILE_ARB_CLEAR_EN to build the zero-sweep engine behind clr_start/clr_busy.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal arbitration; clr_start accepted here
// ST_SWEEP | writing zero to address cnt each cycle, arbitration frozen
module regfile_write_arbiter #(
  parameter int M = 3,
  parameter int N = 3,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req,
  input  logic [R*(M+1)-1:0]   req_addr,
  input  logic [R*(N+1)-1:0]   req_data,
  output logic [R-1:0]         gnt,
  output logic                 we,
  output logic [M:0]           wa,
  output logic [N:0]           wd,
  input  logic                 clr_start,
  output logic                 clr_busy
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_nxt;
  logic          win_vld;
  logic          arb_block;
  logic          xfer;
  logic          sweep_on;
  logic [M:0]    cnt;
  int            scan;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int k = 0; k < R; k++) begin
      scan = (int'(ptr) + k) % R;
      if (!win_vld && req[scan[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
  end

  assign ptr_nxt = (win_idx == PW'(R - 1)) ? '0 : win_idx + 1'b1;
  assign xfer    = win_vld & ~arb_block;

  always_comb begin
    gnt = '0;
    if (xfer) gnt[win_idx] = 1'b1;
  end

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t state;
  state_t state_nxt;
  logic   clr_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clr_accept)    cnt <= '0;
      else if (sweep_on) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    clr_accept = 1'b0;
    sweep_on   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_n && clr_start) begin
          clr_accept = 1'b1;
          state_nxt  = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        sweep_on = 1'b1;
        if (&cnt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign arb_block = ~rst_n | clr_accept | sweep_on;
  assign clr_busy  = clr_accept | sweep_on;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign sweep_on         = 1'b0;
  assign cnt              = '0;
  assign arb_block        = ~rst_n;
  assign clr_busy         = 1'b0;
`endif

  // wa/wd hold their last value on idle cycles; only we drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we  <= 1'b0;
      wa  <= '0;
      wd  <= '0;
      ptr <= '0;
    end else if (sweep_on) begin
      we <= 1'b1;
      wa <= cnt;
      wd <= '0;
    end else if (xfer) begin
      we  <= 1'b1;
      wa  <= req_addr[win_idx*(M+1) +: (M+1)];
      wd  <= req_data[win_idx*(N+1) +: (N+1)];
      ptr <= ptr_nxt;
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, sweep/reset sequences, and random
// traffic checked against a queue-free behavioural model plus a register-file image.
module tb_regfile_write_arbiter;

  localparam int M = 3;
  localparam int N = 3;
  localparam int R = 4;
  localparam int DEPTH = 16;
`ifdef REGFILE_ARB_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    req;
  logic [R*4-1:0]  req_addr;
  logic [R*4-1:0]  req_data;
  logic [R-1:0]    gnt;
  logic            we;
  logic [M:0]      wa;
  logic [N:0]      wd;
  logic            clr_start;
  logic            clr_busy;

  regfile_write_arbiter #(.M(M), .N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .we(we), .wa(wa), .wd(wd), .clr_start(clr_start), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port.
  logic [N:0] mem [DEPTH];
  always @(posedge clk) if (we === 1'b1) mem[wa] <= wd;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_ptr = 0, m_we = 0, m_wa = 0, m_wd = 0, m_cnt = 0;
  bit m_sweep = 1'b0;
  int gmem [DEPTH];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       we;
    logic [3:0] wa;
    logic [3:0] wd;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++)
      if (r[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cycle(input logic [3:0] r, input logic [15:0] av, input logic [15:0] dv,
                       input logic clr, input logic rn,
                       output logic [3:0] g_obs, output logic b_obs);
    int w;
    logic [3:0] e_gnt;
    logic e_busy;
    req = r; req_addr = av; req_data = dv; clr_start = clr; rst_n = rn;
    #1;
    w = pick(r, m_ptr);
    e_gnt = '0;
    if (rn && !(CLEAR && (m_sweep || clr)) && w >= 0) e_gnt[w] = 1'b1;
    e_busy = CLEAR && (m_sweep || (rn && clr));
    g_obs = gnt;
    b_obs = clr_busy;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("clr_busy", 32'(clr_busy), 32'(e_busy));
    if (m_we != 0) gmem[m_wa] = m_wd;
    if (!rn) begin
      m_we = 0; m_wa = 0; m_wd = 0; m_ptr = 0; m_sweep = 1'b0; m_cnt = 0;
    end else if (m_sweep) begin
      m_we = 1; m_wa = m_cnt; m_wd = 0;
      if (m_cnt == DEPTH - 1) m_sweep = 1'b0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else if (CLEAR && clr) begin
      m_sweep = 1'b1; m_cnt = 0; m_we = 0;
    end else if (w >= 0) begin
      m_we = 1; m_wa = int'(av[w*4 +: 4]); m_wd = int'(dv[w*4 +: 4]);
      m_ptr = (w + 1) % R;
    end else begin
      m_we = 0;
    end
    @(posedge clk);
    #1;
    chk("we", 32'(we), 32'(m_we));
    chk("wa", 32'(wa), 32'(m_wa));
    chk("wd", 32'(wd), 32'(m_wd));
  endtask

  task automatic fill_mem(output logic [3:0] g, output logic b);
    logic [15:0] av, dv;
    for (int k = 0; k < DEPTH; k++) begin
      av = 16'(k);
      dv = 16'((k % 15) + 1);
      cycle(4'b0001, av, dv, 1'b0, 1'b1, g, b);
    end
  endtask

  logic [3:0]  g;
  logic        b;
  logic [15:0] tav, tdv;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; gmem[i] = 0; end
    // Requester i: addr i+3, data i+7.
    tav = {4'd6, 4'd5, 4'd4, 4'd3};
    tdv = {4'd10, 4'd9, 4'd8, 4'd7};
    tbl[0]  = '{4'b1111, 4'b0001, 1'b1, 4'd3, 4'd7};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 4'd5, 4'd9};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 4'd5, 4'd9};
    tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 4'd6, 4'd10};
    tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 4'd3, 4'd7};
    tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 4'd4, 4'd8};
    tbl[6]  = '{4'b1111, 4'b0100, 1'b1, 4'd5, 4'd9};
    tbl[7]  = '{4'b1111, 4'b1000, 1'b1, 4'd6, 4'd10};
    tbl[8]  = '{4'b0010, 4'b0010, 1'b1, 4'd4, 4'd8};
    tbl[9]  = '{4'b0011, 4'b0001, 1'b1, 4'd3, 4'd7};
    tbl[10] = '{4'b0010, 4'b0010, 1'b1, 4'd4, 4'd8};
    tbl[11] = '{4'b0010, 4'b0010, 1'b1, 4'd4, 4'd8};
    tbl[12] = '{4'b1001, 4'b1000, 1'b1, 4'd6, 4'd10};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'd6, 4'd10};

    req = '0; req_addr = '0; req_data = '0; clr_start = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with all requests high.
    for (int i = 0; i < 2; i++) begin
      cycle(4'b1111, tav, tdv, 1'b0, 1'b0, g, b);
      chk("rst_gnt", 32'(g), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
    end

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].req, tav, tdv, 1'b0, 1'b1, g, b);
      chk("tbl_gnt", 32'(g), 32'(tbl[i].gnt));
      chk("tbl_we", 32'(we), 32'(tbl[i].we));
      chk("tbl_wa", 32'(wa), 32'(tbl[i].wa));
      chk("tbl_wd", 32'(wd), 32'(tbl[i].wd));
    end
    chk("rd_addr5", 32'(mem[5]), 32'd9);

`ifdef REGFILE_ARB_CLEAR_EN
    // Full sweep with a competing request from requester 3.
    fill_mem(g, b);
    tav = 16'h2000;
    tdv = 16'hA000;
    cycle(4'b1000, tav, tdv, 1'b1, 1'b1, g, b);
    chk("clr_accept_gnt", 32'(g), 32'd0);
    chk("clr_accept_busy", 32'(b), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(4'b1000, tav, tdv, (k == 3) ? 1'b1 : 1'b0, 1'b1, g, b);
      chk("sweep_gnt", 32'(g), 32'd0);
      chk("sweep_we", 32'(we), 32'd1);
      chk("sweep_wa", 32'(wa), 32'(k));
      chk("sweep_wd", 32'(wd), 32'd0);
    end
    cycle(4'b1000, tav, tdv, 1'b0, 1'b1, g, b);
    chk("post_sweep_gnt", 32'(g), 32'b1000);
    chk("post_sweep_busy", 32'(b), 32'd0);
    cycle(4'b0000, tav, tdv, 1'b0, 1'b1, g, b);
    cycle(4'b0000, tav, tdv, 1'b0, 1'b1, g, b);
    for (int i = 0; i < DEPTH; i++)
      chk("sweep_mem", 32'(mem[i]), (i == 2) ? 32'hA : 32'd0);

    // Reset in the cycle where address 7 is being written.
    fill_mem(g, b);
    cycle(4'b0000, tav, tdv, 1'b1, 1'b1, g, b);
    for (int k = 0; k < 8; k++) cycle(4'b0000, tav, tdv, 1'b0, 1'b1, g, b);
    chk("abort_wa7", 32'(wa), 32'd7);
    cycle(4'b0000, tav, tdv, 1'b0, 1'b0, g, b);
    chk("abort_we", 32'(we), 32'd0);
    cycle(4'b0000, tav, tdv, 1'b0, 1'b1, g, b);
    chk("abort_busy", 32'(b), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 7)      chk("abort_zero", 32'(mem[i]), 32'd0);
      else if (i > 7) chk("abort_keep", 32'(mem[i]), 32'((i % 15) + 1));
    end
`else
    // clr_start has no effect when the sweep engine is not built.
    tav = 16'h2000;
    tdv = 16'hA000;
    cycle(4'b1000, tav, tdv, 1'b1, 1'b1, g, b);
    chk("noclr_gnt", 32'(g), 32'b1000);
    chk("noclr_busy", 32'(b), 32'd0);
    chk("noclr_wa", 32'(wa), 32'd2);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) != 0), g, b);
    end
    cycle(4'b0000, 16'h0, 16'h0, 1'b0, 1'b1, g, b);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(mem[i]), 32'(gmem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
